dm_cache_ctrl: RTL

Direct-mapped, write-through, no-write-allocate cache controller between a single CPU requester and the 32-word single-port backing RAM. It holds a small tag/data store, answers read hits locally, and sequences the RAM for read fills and write-throughs. It is the only master of the RAM's address/data/rden/wren pins.

---
 rtl/dm_cache_ctrl_pkg.sv | 21 ++
 rtl/dm_cache_ctrl_if.sv | 34 +++
 rtl/dm_cache_ctrl_line_store.sv | 49 ++++
 rtl/dm_cache_ctrl.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/dm_cache_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// cache_ctrl_pkg : shared types and default geometry for dm_cache_ctrl
// Revision: 1.0
// ============================================================================
package cache_ctrl_pkg;

   localparam int unsigned CACHE_ADDR_W  = 5;
   localparam int unsigned CACHE_DATA_W  = 32;
   localparam int unsigned CACHE_INDEX_W = 3;
   localparam int unsigned STAT_W        = 16;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOOKUP = 2'd1,
      FILL   = 2'd2,
      WRITE  = 2'd3
   } state_e;

endpackage
`default_nettype wire

// File: rtl/dm_cache_ctrl_if.sv
`default_nettype none
// ============================================================================
// dm_cache_ctrl_if : CPU request/response and backing-RAM pins of the cache
// Revision: 1.0
// ============================================================================
interface dm_cache_ctrl_if #(
   parameter int unsigned ADDR_W = 5,
   parameter int unsigned DATA_W = 32
);
   logic              cpu_req;
   logic              cpu_we;
   logic [ADDR_W-1:0] cpu_addr;
   logic [DATA_W-1:0] cpu_wdata;
   logic              cpu_ready;
   logic              cpu_done;
   logic [DATA_W-1:0] cpu_rdata;
   logic [ADDR_W-1:0] mem_address;
   logic [DATA_W-1:0] mem_data;
   logic              mem_rden;
   logic              mem_wren;
   logic [DATA_W-1:0] mem_q;

   // Controller side: serves the CPU, masters the RAM.
   modport slave (
      input  cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_q,
      output cpu_ready, cpu_done, cpu_rdata, mem_address, mem_data, mem_rden, mem_wren
   );

   modport master (
      output cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_q,
      input  cpu_ready, cpu_done, cpu_rdata, mem_address, mem_data, mem_rden, mem_wren
   );
endinterface
`default_nettype wire

// File: rtl/dm_cache_ctrl_line_store.sv
`default_nettype none
// ============================================================================
// cache_line_store : valid/tag/data arrays, combinational lookup, one write port
// Revision: 1.0
// ============================================================================
module cache_line_store #(
   parameter int unsigned INDEX_W = 3,
   parameter int unsigned TAG_W   = 2,
   parameter int unsigned DATA_W  = 32
) (
   input  logic               clock,
   input  logic               i_rst,
   input  logic [INDEX_W-1:0] rd_index_i,
   output logic               rd_valid_o,
   output logic [TAG_W-1:0]   rd_tag_o,
   output logic [DATA_W-1:0]  rd_data_o,
   input  logic               wr_en_i,
   input  logic [INDEX_W-1:0] wr_index_i,
   input  logic [TAG_W-1:0]   wr_tag_i,
   input  logic [DATA_W-1:0]  wr_data_i
);
   localparam int unsigned LINES = 2 ** INDEX_W;

   logic [LINES-1:0]  valid_q;
   logic [TAG_W-1:0]  tag_q  [LINES];
   logic [DATA_W-1:0] data_q [LINES];

   // Every write (fill or write-hit) leaves the line valid with the given tag.
   always_ff @(posedge clock) begin
      if (i_rst) begin
         valid_q <= '0;
      end else if (wr_en_i) begin
         valid_q[wr_index_i] <= 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (wr_en_i) begin
         tag_q[wr_index_i]  <= wr_tag_i;
         data_q[wr_index_i] <= wr_data_i;
      end
   end

   assign rd_valid_o = valid_q[rd_index_i];
   assign rd_tag_o   = tag_q[rd_index_i];
   assign rd_data_o  = data_q[rd_index_i];

endmodule
`default_nettype wire

// File: rtl/dm_cache_ctrl.sv
`default_nettype none
// ============================================================================
// dm_cache_ctrl : direct-mapped write-through no-write-allocate cache controller
// Optional hit/miss counters built when CACHE_STATS_EN is defined.
// Revision: 1.0
// ============================================================================
module dm_cache_ctrl
   import cache_ctrl_pkg::*;
#(
   parameter int unsigned ADDR_W  = CACHE_ADDR_W,
   parameter int unsigned DATA_W  = CACHE_DATA_W,
   parameter int unsigned INDEX_W = CACHE_INDEX_W
) (
   input  logic              clock,
   input  logic              i_rst,
   dm_cache_ctrl_if.slave    bus,
   output logic [STAT_W-1:0] stat_hits,
   output logic [STAT_W-1:0] stat_misses
);
   localparam int unsigned TAG_W = ADDR_W - INDEX_W;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              we_q, we_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic              done_q, done_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;

   logic [INDEX_W-1:0] index;
   logic [TAG_W-1:0]   tag;
   logic               line_valid;
   logic [TAG_W-1:0]   line_tag;
   logic [DATA_W-1:0]  line_data;
   logic               hit;
   logic               st_wr_en;
   logic [DATA_W-1:0]  st_wr_data;
   logic [ADDR_W-1:0]  mem_addr;
   logic [DATA_W-1:0]  mem_wdata;
   logic               rden;
   logic               wren;

   assign index = addr_q[INDEX_W-1:0];
   assign tag   = addr_q[ADDR_W-1:INDEX_W];
   assign hit   = line_valid && (line_tag == tag);

   cache_line_store #(
      .INDEX_W (INDEX_W),
      .TAG_W   (TAG_W),
      .DATA_W  (DATA_W)
   ) u_store (
      .clock      (clock),
      .i_rst      (i_rst),
      .rd_index_i (index),
      .rd_valid_o (line_valid),
      .rd_tag_o   (line_tag),
      .rd_data_o  (line_data),
      .wr_en_i    (st_wr_en),
      .wr_index_i (index),
      .wr_tag_i   (tag),
      .wr_data_i  (st_wr_data)
   );

   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      we_d       = we_q;
      wdata_d    = wdata_q;
      done_d     = 1'b0;
      rdata_d    = rdata_q;
      st_wr_en   = 1'b0;
      st_wr_data = wdata_q;
      mem_addr   = '0;
      mem_wdata  = '0;
      rden       = 1'b0;
      wren       = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.cpu_req) begin
               addr_d  = bus.cpu_addr;
               we_d    = bus.cpu_we;
               wdata_d = bus.cpu_wdata;
               state_d = LOOKUP;
            end
         end
         LOOKUP: begin
            if (we_q) begin
               state_d = WRITE;
            end else if (hit) begin
               rdata_d = line_data;
               done_d  = 1'b1;
               state_d = IDLE;
            end else begin
               state_d = FILL;
            end
         end
         FILL: begin
            rden       = 1'b1;
            mem_addr   = addr_q;
            st_wr_en   = 1'b1;
            st_wr_data = bus.mem_q;
            rdata_d    = bus.mem_q;
            done_d     = 1'b1;
            state_d    = IDLE;
         end
         WRITE: begin
            // Write-through: RAM always written; the line only if it is resident.
            wren      = 1'b1;
            mem_addr  = addr_q;
            mem_wdata = wdata_q;
            st_wr_en  = hit;
            done_d    = 1'b1;
            state_d   = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (i_rst) begin
         state_q <= IDLE;
         addr_q  <= '0;
         we_q    <= 1'b0;
         wdata_q <= '0;
         done_q  <= 1'b0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         we_q    <= we_d;
         wdata_q <= wdata_d;
         done_q  <= done_d;
         rdata_q <= rdata_d;
      end
   end

   // Enables are gated by reset so an abandoned WRITE never lands in RAM.
   assign bus.cpu_ready   = (state_q == IDLE) && !i_rst;
   assign bus.cpu_done    = done_q;
   assign bus.cpu_rdata   = rdata_q;
   assign bus.mem_address = mem_addr;
   assign bus.mem_data    = mem_wdata;
   assign bus.mem_rden    = rden && !i_rst;
   assign bus.mem_wren    = wren && !i_rst;

`ifdef CACHE_STATS_EN
   logic [STAT_W-1:0] hits_q;
   logic [STAT_W-1:0] misses_q;
   logic              rd_lookup;

   assign rd_lookup = (state_q == LOOKUP) && !we_q;

   always_ff @(posedge clock) begin
      if (i_rst) begin
         hits_q   <= '0;
         misses_q <= '0;
      end else if (rd_lookup) begin
         if (hit && (hits_q != '1)) begin
            hits_q <= hits_q + 1'b1;
         end
         if (!hit && (misses_q != '1)) begin
            misses_q <= misses_q + 1'b1;
         end
      end
   end

   assign stat_hits   = hits_q;
   assign stat_misses = misses_q;
`else
   assign stat_hits   = '0;
   assign stat_misses = '0;
`endif

endmodule
`default_nettype wire
